// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD digit feeder.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int         C_BCD_DIGITS = 5;
  localparam bcd_digit_t C_SAT_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Wraps within 4 bits; no carry leaves the digit.
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_digit_feeder.sv
// Sequential double-dabble converter feeding the 4-digit 7-segment display.
// Build option OVERFLOW_SAT_EN: on overflow the display digits saturate to 9999.
module bin2bcd_digit_feeder
  import bin2bcd_pkg::*;
#(
  parameter int C_BIN_WIDTH   = 14,
  parameter int C_DIGIT_ORDER = 0
) (
  input  logic                   SPLB_Clk,
  input  logic                   SPLB_Rst,
  input  logic                   start,
  input  logic [C_BIN_WIDTH-1:0] bin_in,
  input  logic [0:3]             dp_in,
  output logic [0:3]             Val0,
  output logic [0:3]             Val1,
  output logic [0:3]             Val2,
  output logic [0:3]             Val3,
  output logic [0:3]             dps,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int ACC_W = 4 * C_BCD_DIGITS;

  if (C_BIN_WIDTH < 4 || C_BIN_WIDTH > 16) begin : g_bad_width
    $error("bin2bcd_digit_feeder: C_BIN_WIDTH must be in 4..16");
  end

  state_t                 state;
  logic [C_BIN_WIDTH-1:0] shift_q;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W-1:0]       acc_next;
  logic [0:3]             dp_hold;
  logic [4:0]             count;

  for (genvar i = 0; i < C_BCD_DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit   (acc[4*i +: 4]),
      .adjusted(acc_adj[4*i +: 4])
    );
  end

  assign acc_next = {acc_adj[ACC_W-2:0], shift_q[C_BIN_WIDTH-1]};

  bcd_digit_t final_digit [4];
  bcd_digit_t shown       [4];
  logic       ovf_next;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    ovf_next = |acc_next[ACC_W-1 -: 4];
    for (int i = 0; i < 4; i++) begin
      final_digit[i] = acc_next[4*i +: 4];
`ifdef OVERFLOW_SAT_EN
      if (ovf_next) final_digit[i] = C_SAT_DIGIT;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      shown[i] = (C_DIGIT_ORDER == 0) ? final_digit[i] : final_digit[3-i];
    end
  end

  // Outputs are registered on the last CONV edge so they become visible,
  // together with done, in the LOAD cycle and never show partial results.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
    if (SPLB_Rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      acc      <= '0;
      dp_hold  <= '0;
      count    <= '0;
      Val0     <= '0;
      Val1     <= '0;
      Val2     <= '0;
      Val3     <= '0;
      dps      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_q <= bin_in;
            dp_hold <= dp_in;
            acc     <= '0;
            count   <= 5'(C_BIN_WIDTH);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc     <= acc_next;
          shift_q <= shift_q << 1;
          count   <= count - 5'd1;
          if (count == 5'd1) begin
            Val0     <= shown[0];
            Val1     <= shown[1];
            Val2     <= shown[2];
            Val3     <= shown[3];
            dps      <= dp_hold;
            overflow <= ovf_next;
            done     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_digit_feeder.sv
// Randomised self-checking bench for bin2bcd_digit_feeder (14-bit ones-first and 16-bit thousands-first instances).
module tb_bin2bcd_digit_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic [13:0] bin_a   = '0;
  logic [0:3]  dp_a    = '0;
  logic [0:3]  a_v0, a_v1, a_v2, a_v3, a_dps;
  logic        a_busy, a_done, a_ovf;

  logic        start_b = 1'b0;
  logic [15:0] bin_b   = '0;
  logic [0:3]  dp_b    = '0;
  logic [0:3]  b_v0, b_v1, b_v2, b_v3, b_dps;
  logic        b_busy, b_done, b_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_digit_feeder #(.C_BIN_WIDTH(14), .C_DIGIT_ORDER(0)) u_dut_a (
    .SPLB_Clk(clk), .SPLB_Rst(rst), .start(start_a), .bin_in(bin_a), .dp_in(dp_a),
    .Val0(a_v0), .Val1(a_v1), .Val2(a_v2), .Val3(a_v3), .dps(a_dps),
    .busy(a_busy), .done(a_done), .overflow(a_ovf)
  );

  bin2bcd_digit_feeder #(.C_BIN_WIDTH(16), .C_DIGIT_ORDER(1)) u_dut_b (
    .SPLB_Clk(clk), .SPLB_Rst(rst), .start(start_b), .bin_in(bin_b), .dp_in(dp_b),
    .Val0(b_v0), .Val1(b_v1), .Val2(b_v2), .Val3(b_v3), .dps(b_dps),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  // Reference: decimal digits by division, then saturation and ordering; bits [3:0] = Val0.
  function automatic logic [15:0] model_vals(input int unsigned v, input int order);
    int unsigned d [4];
    int unsigned t;
    logic [15:0] r;
    t = v;
    for (int i = 0; i < 4; i++) begin
      d[i] = t % 10;
      t    = t / 10;
    end
`ifdef OVERFLOW_SAT_EN
    if (v > 9999) for (int i = 0; i < 4; i++) d[i] = 9;
`endif
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(order == 0 ? d[i] : d[3-i]);
    return r;
  endfunction

  function automatic logic [15:0] obs_vals(input bit wide);
    return wide ? {b_v3, b_v2, b_v1, b_v0} : {a_v3, a_v2, a_v1, a_v0};
  endfunction

  function automatic logic obs_busy(input bit wide);
    return wide ? b_busy : a_busy;
  endfunction

  function automatic logic obs_done(input bit wide);
    return wide ? b_done : a_done;
  endfunction

  function automatic logic obs_ovf(input bit wide);
    return wide ? b_ovf : a_ovf;
  endfunction

  function automatic logic [3:0] obs_dps(input bit wide);
    return wide ? b_dps : a_dps;
  endfunction

  task automatic drive(input bit wide, input bit s, input int unsigned value, input logic [3:0] d);
    if (wide) begin
      start_b = s; bin_b = value[15:0]; dp_b = d;
    end else begin
      start_a = s; bin_a = value[13:0]; dp_a = d;
    end
  endtask

  // One conversion: start in the next cycle, wait for done, check latency and results.
  // Returns in the done cycle, so a following call starts in the cycle after done.
  task automatic run_conv(input bit wide, input int unsigned value, input logic [3:0] dp_val,
                          input bit poke_mid, input string name);
    int          n;
    int          width;
    logic [15:0] prev_v;
    logic [15:0] exp_v;
    width  = wide ? 16 : 14;
    prev_v = obs_vals(wide);
    exp_v  = model_vals(value, wide ? 1 : 0);
    @(posedge clk); #1;
    checks++;
    if (obs_busy(wide) !== 1'b0 || obs_done(wide) !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b done=%b, required 0 0", name, obs_busy(wide), obs_done(wide));
    end
    drive(wide, 1'b1, value, dp_val);
    @(posedge clk); #1;
    drive(wide, 1'b0, 0, 4'h0);
    n = 1;
    while (obs_done(wide) !== 1'b1 && n < 40) begin
      if (n == 1) begin
        checks++;
        if (obs_busy(wide) !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b, required 1", name, obs_busy(wide));
        end
      end
      if (n == 5) begin
        checks++;
        if (obs_vals(wide) !== prev_v) begin
          errors++;
          $display("FAIL %s hold: got %h, required %h", name, obs_vals(wide), prev_v);
        end
        if (poke_mid) drive(wide, 1'b1, 777, 4'hF);
      end
      if (n == 6) drive(wide, 1'b0, 0, 4'h0);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != width + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", name, n, width + 1);
    end
    checks++;
    if (obs_vals(wide) !== exp_v || obs_dps(wide) !== dp_val ||
        obs_ovf(wide) !== (value > 9999) || obs_busy(wide) !== 1'b1) begin
      errors++;
      $display("FAIL %s result (in=%0d): vals=%h dps=%b ovf=%b busy=%b, required vals=%h dps=%b ovf=%b busy=1",
               name, value, obs_vals(wide), obs_dps(wide), obs_ovf(wide), obs_busy(wide),
               exp_v, dp_val, value > 9999);
    end
  endtask

  // No done pulse, busy low and outputs unchanged over a window of cycles.
  task automatic expect_quiet(input bit wide, input int cycles, input string name);
    int          pulses;
    logic [15:0] held;
    pulses = 0;
    held   = obs_vals(wide);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (obs_done(wide) === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || obs_busy(wide) !== 1'b0 || obs_vals(wide) !== held) begin
      errors++;
      $display("FAIL %s quiet: done pulses=%0d busy=%b vals=%h, required 0 0 %h",
               name, pulses, obs_busy(wide), obs_vals(wide), held);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({a_v3, a_v2, a_v1, a_v0, a_dps} !== 20'h0 || a_busy !== 1'b0 ||
        a_done !== 1'b0 || a_ovf !== 1'b0 ||
        {b_v3, b_v2, b_v1, b_v0, b_dps} !== 20'h0 || b_busy !== 1'b0 ||
        b_done !== 1'b0 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: a=%h/%b/%b%b%b b=%h/%b/%b%b%b, required all zero", name,
               {a_v3, a_v2, a_v1, a_v0}, a_dps, a_busy, a_done, a_ovf,
               {b_v3, b_v2, b_v1, b_v0}, b_dps, b_busy, b_done, b_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_conv(1'b0, 1234, 4'b0100, 1'b0, "basic_1234");
  endtask

  task automatic test_reset_mid_conv();
    drive(1'b0, 1'b1, 8888, 4'b1010);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 4'h0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("reset_mid_conv");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_quiet(1'b0, 20, "reset_no_done");
    run_conv(1'b0, 42, 4'b0001, 1'b0, "after_reset_42");
  endtask

  task automatic test_back_to_back();
    run_conv(1'b0, 9999, 4'b1111, 1'b0, "b2b_9999");
    run_conv(1'b0, 0, 4'b0000, 1'b0, "b2b_zero");
  endtask

  task automatic test_overflow();
    run_conv(1'b0, 12345, 4'b0010, 1'b0, "ovf_12345");
    run_conv(1'b0, 16383, 4'b1000, 1'b0, "max_14bit");
    run_conv(1'b0, 77, 4'b0000, 1'b0, "ovf_clears");
  endtask

  task automatic test_ignored_starts();
    run_conv(1'b0, 500, 4'b0100, 1'b1, "busy_start_500");
    expect_quiet(1'b0, 20, "busy_start_single_done");
    run_conv(1'b0, 321, 4'b0011, 1'b0, "load_start_321");
    drive(1'b0, 1'b1, 4321, 4'b1100);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 4'h0);
    expect_quiet(1'b0, 20, "load_start_ignored");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_conv(1'b0, $urandom_range(0, 16383), 4'($urandom), 1'b0, "rand14");
    end
    for (int i = 0; i < 4; i++) begin
      run_conv(1'b1, $urandom_range(0, 65535), 4'($urandom), 1'b0, "rand16");
    end
  endtask

  task automatic test_wide();
    run_conv(1'b1, 65535, 4'b0110, 1'b0, "wide_65535");
    run_conv(1'b1, 0, 4'b0000, 1'b0, "wide_zero");
    run_conv(1'b1, 9876, 4'b1001, 1'b0, "wide_9876");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_conv();
    test_back_to_back();
    test_overflow();
    test_ignored_starts();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
